// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, ALU ops, control word and default program for the single-cycle MIPS core
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   // ROM words that can carry program content; the rest of the ROM reads as NOP
   localparam int PROG_WORDS = 16;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   typedef struct packed {
      logic    reg_dst;
      logic    alu_src;
      logic    mem_to_reg;
      logic    reg_write;
      logic    mem_write;
      logic    branch;
      logic    jump;
      alu_op_t alu_op;
   } ctrl_t;

   // addi $1,$0,5 ; addi $2,$0,7 ; add $3,$1,$2 ; j 3
   localparam logic [PROG_WORDS*32-1:0] PROG_DEFAULT = {
      {(PROG_WORDS-4){32'h0000_0000}},
      32'h0800_0003,
      32'h0022_1820,
      32'h2002_0007,
      32'h2001_0005
   };

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32x32 register file, two async read ports, one sync write port, $0 hardwired to zero
module mips_regfile
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);

   logic [31:0] registradores [0:31];

   // write port; $0 is never written so it stays at its reset value of zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) registradores[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         registradores[wa] <= wd;
      end
   end

   // read ports see the pre-edge contents, so a same-cycle write is not forwarded
   always_comb begin
      rd1 = (ra1 == 5'd0) ? 32'h0 : registradores[ra1];
      rd2 = (ra2 == 5'd0) ? 32'h0 : registradores[ra2];
   end

endmodule

// File: rtl/mips_ciclo_unico.sv
// rtl/mips_ciclo_unico.sv - single-cycle MIPS-I subset core with internal ROM/RAM; MIPS_DEBUG_PORTS_EN adds dbg_pc/dbg_instr
module mips_ciclo_unico
   import mips_pkg::*;
#(
   parameter int                        IMEM_DEPTH = 64,
   parameter int                        DMEM_DEPTH = 64,
   parameter logic [PROG_WORDS*32-1:0]  ROM_PROG   = PROG_DEFAULT
)(
   input  logic        clk,
   input  logic        rst_n
`ifdef MIPS_DEBUG_PORTS_EN
   ,
   output logic [31:0] dbg_pc,
   output logic [31:0] dbg_instr
`endif
);

   localparam int IW = $clog2(IMEM_DEPTH);
   localparam int DW = $clog2(DMEM_DEPTH);

   logic [31:0]   pc;
   logic [31:0]   pc_next;
   logic [31:0]   pc_plus4;
   logic [31:0]   instr;
   logic [IW-1:0] pc_idx;
   ctrl_t         ctrl;

   logic [5:0]    opcode;
   logic [4:0]    rs, rt, rd, shamt;
   logic [5:0]    funct;
   logic [31:0]   imm_sext;

   logic [31:0]   rd1, rd2;
   logic [31:0]   alu_b, alu_y;
   logic [31:0]   wb_data;
   logic [4:0]    wb_addr;

   logic [31:0]   dmem [0:DMEM_DEPTH-1];
   logic [DW-1:0] d_idx;
   logic [31:0]   d_rdata;

   assign opcode   = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign shamt    = instr[10:6];
   assign funct    = instr[5:0];
   assign imm_sext = {{16{instr[15]}}, instr[15:0]};

   assign pc_idx   = pc[IW+1:2];
   assign pc_plus4 = pc + 32'd4;

`ifdef MIPS_DEBUG_PORTS_EN
   assign dbg_pc    = pc;
   assign dbg_instr = instr;
`endif

   // instruction ROM: program words from ROM_PROG, everything else reads as NOP
   always_comb begin
      instr = 32'h0;
      for (int i = 0; i < PROG_WORDS; i++) begin
         if (pc_idx == IW'(i)) instr = ROM_PROG[i*32 +: 32];
      end
   end

   // decoder: unsupported encodings (incl. R-type with nonzero shamt) leave all controls off
   always_comb begin
      ctrl = '0;
      ctrl.alu_op = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            if (shamt == 5'd0) begin
               ctrl.reg_dst   = 1'b1;
               ctrl.reg_write = 1'b1;
               case (funct)
                  FN_ADD:  ctrl.alu_op = ALU_ADD;
                  FN_SUB:  ctrl.alu_op = ALU_SUB;
                  FN_AND:  ctrl.alu_op = ALU_AND;
                  FN_OR:   ctrl.alu_op = ALU_OR;
                  FN_SLT:  ctrl.alu_op = ALU_SLT;
                  default: ctrl.reg_write = 1'b0;
               endcase
            end
         end
         OP_ADDI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_LW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALU_SUB;
         end
         OP_J: begin
            ctrl.jump = 1'b1;
         end
         default: ;
      endcase
   end

   mips_regfile regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (rs),
      .ra2   (rt),
      .rd1   (rd1),
      .rd2   (rd2),
      .we    (ctrl.reg_write),
      .wa    (wb_addr),
      .wd    (wb_data)
   );

   // ALU: wrap-around arithmetic, signed set-less-than
   always_comb begin
      alu_b = ctrl.alu_src ? imm_sext : rd2;
      case (ctrl.alu_op)
         ALU_SUB: alu_y = rd1 - alu_b;
         ALU_AND: alu_y = rd1 & alu_b;
         ALU_OR:  alu_y = rd1 | alu_b;
         ALU_SLT: alu_y = {31'h0, ($signed(rd1) < $signed(alu_b))};
         default: alu_y = rd1 + alu_b;
      endcase
   end

   assign d_idx   = alu_y[DW+1:2];
   assign d_rdata = dmem[d_idx];
   assign wb_data = ctrl.mem_to_reg ? d_rdata : alu_y;
   assign wb_addr = ctrl.reg_dst ? rd : rt;

   // data RAM: cleared on reset, written by sw on the clock edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
      end else if (ctrl.mem_write) begin
         dmem[d_idx] <= rd2;
      end
   end

   // next-PC selection: jump, taken branch, or fall-through
   always_comb begin
      pc_next = pc_plus4;
      if (ctrl.jump)
         pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      else if (ctrl.branch && (alu_y == 32'h0))
         pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
   end

   // program counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= 32'h0;
      else        pc <= pc_next;
   end

endmodule

// File: tb/tb_mips_ciclo_unico.sv
// tb/tb_mips_ciclo_unico.sv - directed self-checking bench for mips_ciclo_unico
module tb_mips_ciclo_unico;
   import mips_pkg::*;

   // sw/lw through address 8: addi $4,$0,-1 ; sw $4,8($0) ; lw $5,8($0) ; j 3
   localparam logic [PROG_WORDS*32-1:0] PROG_MEM = {
      {(PROG_WORDS-4){32'h0}},
      32'h0800_0003, 32'h8C05_0008, 32'hAC04_0008, 32'h2004_FFFF
   };
   // $0 write discarded, beq skips: addi $0,$0,9 ; beq $0,$0,+1 ; addi $6,$0,1 ; j 3
   localparam logic [PROG_WORDS*32-1:0] PROG_BR = {
      {(PROG_WORDS-4){32'h0}},
      32'h0800_0003, 32'h2006_0001, 32'h1000_0001, 32'h2000_0009
   };
   // ALU: $7=0x7FFF, $8=-1, add/sub/slt/and/or/slt(rev), j 8
   localparam logic [PROG_WORDS*32-1:0] PROG_ALU = {
      {(PROG_WORDS-9){32'h0}},
      32'h0800_0008, 32'h0107_702A, 32'h00E8_6825, 32'h00E8_6024,
      32'h00E8_582A, 32'h00E8_5022, 32'h00E8_4820, 32'h2008_FFFF, 32'h2007_7FFF
   };

   logic clk;
   logic rst0;
   logic rst1;
   int   tests;
   int   fails;

   mips_ciclo_unico dut     (.clk(clk), .rst_n(rst0));
   mips_ciclo_unico #(.ROM_PROG(PROG_MEM)) dut_mem (.clk(clk), .rst_n(rst1));
   mips_ciclo_unico #(.ROM_PROG(PROG_BR))  dut_br  (.clk(clk), .rst_n(rst1));
   mips_ciclo_unico #(.ROM_PROG(PROG_ALU)) dut_alu (.clk(clk), .rst_n(rst1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst0  = 1'b0;
      rst1  = 1'b0;
      #1;
      check("reset_pc",   dut.pc, 32'h0);
      check("reset_r1",   dut.regfile.registradores[1], 32'h0);
      check("reset_dmem", dut_mem.dmem[2], 32'h0);
      #1;
      rst0 = 1'b1;
      rst1 = 1'b1;

      repeat (10) @(posedge clk);
      #1;
      check("run_r1", dut.regfile.registradores[1], 32'd5);
      check("run_r2", dut.regfile.registradores[2], 32'd7);
      check("run_r3", dut.regfile.registradores[3], 32'd12);
      check("run_pc", dut.pc, 32'd12);

      repeat (20) @(posedge clk);
      #1;
      check("halt_pc", dut.pc, 32'd12);
      check("halt_r3", dut.regfile.registradores[3], 32'd12);
      check("halt_r1", dut.regfile.registradores[1], 32'd5);

      #2;
      rst0 = 1'b0;
      #1;
      check("midrst_pc", dut.pc, 32'h0);
      check("midrst_r1", dut.regfile.registradores[1], 32'h0);
      check("midrst_r3", dut.regfile.registradores[3], 32'h0);
      @(negedge clk);
      rst0 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rerun_partial_r2", dut.regfile.registradores[2], 32'd7);
      check("rerun_partial_r3", dut.regfile.registradores[3], 32'h0);
      repeat (8) @(posedge clk);
      #1;
      check("rerun_r3", dut.regfile.registradores[3], 32'd12);
      check("rerun_pc", dut.pc, 32'd12);

      check("mem_r4",   dut_mem.regfile.registradores[4], 32'hFFFF_FFFF);
      check("mem_dmem", dut_mem.dmem[2], 32'hFFFF_FFFF);
      check("mem_r5",   dut_mem.regfile.registradores[5], 32'hFFFF_FFFF);

      check("br_r0", dut_br.regfile.registradores[0], 32'h0);
      check("br_r6", dut_br.regfile.registradores[6], 32'h0);
      check("br_pc", dut_br.pc, 32'd12);

      check("alu_r7",  dut_alu.regfile.registradores[7],  32'h0000_7FFF);
      check("alu_r8",  dut_alu.regfile.registradores[8],  32'hFFFF_FFFF);
      check("alu_add", dut_alu.regfile.registradores[9],  32'h0000_7FFE);
      check("alu_sub", dut_alu.regfile.registradores[10], 32'h0000_8000);
      check("alu_slt", dut_alu.regfile.registradores[11], 32'h0);
      check("alu_and", dut_alu.regfile.registradores[12], 32'h0000_7FFF);
      check("alu_or",  dut_alu.regfile.registradores[13], 32'hFFFF_FFFF);
      check("alu_slt_rev", dut_alu.regfile.registradores[14], 32'h1);
      check("alu_pc",  dut_alu.pc, 32'd32);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
